digitron_scan_ctrl: RTL and testbench
=====================================

Name: digitron_scan_ctrl

Overview:
- Scan scheduler for the 4-digit multiplexed seven-segment display.
- Owns a double-buffered digit store (shadow written by requesters, active shown on glass) and time-multiplexes the shared segment bus across 4 digit selects.
- Inserts an all-off blanking interval between digits to suppress ghosting.
- Commits shadow to active only at frame boundaries so a multi-digit update never tears.

Parameters:
- TICK_CYCLES, 50000, CLK cycles per digit slot (1 ms at 50 MHz); must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 500, cycles at the start of each slot with all selects off; must be >= 1.

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RSTn  in  1  synchronous active-low reset
- enable  in  1  1 = scanning; 0 = display dark
- wr_valid  in  1  requester presents a digit write
- wr_ready  out  1  block can accept a write this cycle
- wr_addr  in  2  digit index, 0 = rightmost (select bit 0)
- wr_data  in  5  [3:0] hex value, [4] decimal point
- Digitron_Out  out  8  segments, active-high, bit7 = dp, bits6..0 = g..a
- DigitronCS_Out  out  4  digit selects, active-low, one-cold while showing
- scan_idx  out  2  digit currently in its slot
- frame_done  out  1  one-cycle pulse at each shadow-to-active commit

Behaviour:
- Reset (RSTn=0 at an edge): state BLANK, scan_idx=0, slot counter=0, shadow and active buffers = 5'h00 per digit, Digitron_Out=8'h00, DigitronCS_Out=4'b1111, wr_ready=0, frame_done=0, dirty=0. Reset mid-slot or mid-write discards everything; a write in a reset cycle is not accepted.
- FSM states IDLE, BLANK, SHOW. All outputs registered and updated on the same edge as the state change.
  - IDLE: CS=1111, segs=00. On enable=1, go to BLANK with scan_idx=0 and counter=0.
  - BLANK: CS=1111, segs=00 for BLANK_CYCLES cycles, then SHOW.
  - SHOW: CS = one-cold at scan_idx (idx0 -> 1110, idx3 -> 0111); segs = encode(active[scan_idx]). Lasts TICK_CYCLES-BLANK_CYCLES cycles. Then go to BLANK with scan_idx+1, wrapping 3 -> 0.
  - enable=0 in any state: IDLE on the next edge. Buffers are retained.
- Slot period is exactly TICK_CYCLES; frame period is 4*TICK_CYCLES.
- Encode, for value 0..F: 3f,06,5b,4f,66,6d,7d,07,7f,6f,77,7c,39,5e,79,71. Bit7 = dp bit.
- Write handshake: a write is accepted when wr_valid and wr_ready are both 1 at an edge. It writes shadow[wr_addr] and sets dirty. Last write wins; back-to-back writes accepted every cycle.
- Commit cycle = the final SHOW cycle of scan_idx=3.
  - In the commit cycle, wr_ready=0 (wr_ready is 1 in all other non-reset cycles, including IDLE).
  - If dirty=1: active <= shadow, dirty <= 0, frame_done=1 on the following cycle.
  - If dirty=0: no commit and no pulse.
  - A write held across the commit cycle is accepted the next cycle and shown the following frame.
- In IDLE there are no commit cycles. Writes accumulate in shadow and are committed at the first frame end after enable returns.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: during SHOW, digit i (i = 3,2,1) outputs segs=8'h00 when active[i]==5'h00 and every digit above i also qualifies. Digit 0 is never blanked. A digit with dp=1 is never blanked. CS timing is unchanged.
- Undefined: all digits always shown encoded.

Test Plan (TICK_CYCLES=10, BLANK_CYCLES=2):
- Reset then enable=1 -> 2 cycles of CS=1111/segs=00, then 8 cycles CS=1110/segs=3f; slot pattern repeats for 0111 after 30 cycles. frame_done stays 0 because nothing was written.
- Write addr0=5'h05, addr1=5'h1A, addr2=5'h03, addr3=5'h0F in one burst mid-frame -> display unchanged until commit. frame_done pulses once. Next frame shows 6d, f7, 4f, 71 on selects 1110/1101/1011/0111.
- Hold wr_valid high across the commit cycle -> wr_ready=0 exactly in that cycle; write is accepted one cycle later and displayed only after the next frame_done.
- Drop enable mid-SHOW of digit 2 -> next cycle CS=1111/segs=00. Re-enable -> scan restarts at scan_idx=0 with BLANK; buffers retained.
- Assert RSTn=0 for one cycle during a write burst -> all outputs at reset values next cycle; buffers read back 0 (segs=3f after enable).
- LEADING_ZERO_BLANK_EN with digits {3..0}={0,0,7,0} -> digits 3,2 segs=00, digit1=07, digit0=3f. Set dp on digit 3 -> digit3=bf, digit2=3f.

Source files
------------

// File: rtl/digitron_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed seven-segment display with
// double-buffered digit store. Optional macro: LEADING_ZERO_BLANK_EN.
module digitron_scan_ctrl #(
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [7:0] Digitron_Out,
  output logic [3:0] DigitronCS_Out,
  output logic [1:0] scan_idx,
  output logic       frame_done
);

  localparam int unsigned CNT_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 8;

  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_SHOW  = CNT_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                         r_state;
  logic [CNT_W-1:0]               r_cnt;
  logic [IDX_W-1:0]               r_idx;
  digit_t [NUM_DIGITS-1:0]        r_shadow;
  digit_t [NUM_DIGITS-1:0]        r_active;
  logic                           r_dirty;
  logic [SEG_W-1:0]               r_segs;
  logic [NUM_DIGITS-1:0]          r_cs;
  logic                           r_ready;
  logic                           r_frame_done;

  state_t                         w_state_nxt;
  logic [CNT_W-1:0]               w_cnt_nxt;
  logic [IDX_W-1:0]               w_idx_nxt;
  logic [SEG_W-1:0]               w_segs_nxt;
  logic [NUM_DIGITS-1:0]          w_cs_nxt;
  logic                           w_ready_nxt;
  digit_t                         w_digit;
  logic [NUM_DIGITS-1:0]          w_lz;
  logic                           w_commit;
  logic                           w_wr_fire;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h3f;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5b;
      4'h3:    seg7 = 7'h4f;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6d;
      4'h6:    seg7 = 7'h7d;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7f;
      4'h9:    seg7 = 7'h6f;
      4'ha:    seg7 = 7'h77;
      4'hb:    seg7 = 7'h7c;
      4'hc:    seg7 = 7'h39;
      4'hd:    seg7 = 7'h5e;
      4'he:    seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and every more-significant digit are plain zero.
  logic w_lz3, w_lz2, w_lz1;
  assign w_lz3 = (r_active[3] == '0);
  assign w_lz2 = w_lz3 && (r_active[2] == '0);
  assign w_lz1 = w_lz2 && (r_active[1] == '0);
  assign w_lz  = {w_lz3, w_lz2, w_lz1, 1'b0};
`else
  assign w_lz  = '0;
`endif

  // Final SHOW cycle of the last digit: the only point where shadow moves to active.
  assign w_commit  = (r_state == ST_SHOW) && (r_idx == LAST_IDX) && (r_cnt == LAST_SHOW);
  assign w_wr_fire = wr_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_cs_nxt    = '1;
    w_segs_nxt  = '0;
    w_digit     = r_active[0];
    w_ready_nxt = 1'b1;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        ST_BLANK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_BLANK) begin
            w_state_nxt = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (r_cnt == LAST_SHOW) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end

    // Outputs are registered against the state being entered.
    if (w_state_nxt == ST_SHOW) begin
      w_digit    = r_active[w_idx_nxt];
      w_cs_nxt   = ~(4'b0001 << w_idx_nxt);
      w_segs_nxt = w_lz[w_idx_nxt] ? '0 : {w_digit.dp, seg7(w_digit.hex)};
    end

    w_ready_nxt = !((w_state_nxt == ST_SHOW) && (w_idx_nxt == LAST_IDX) &&
                    (w_cnt_nxt == LAST_SHOW));
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_dirty      <= 1'b0;
      r_segs       <= '0;
      r_cs         <= '1;
      r_ready      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_segs       <= w_segs_nxt;
      r_cs         <= w_cs_nxt;
      r_ready      <= w_ready_nxt;
      r_frame_done <= w_commit && r_dirty;
      if (w_wr_fire) begin
        r_shadow[wr_addr] <= digit_t'(wr_data);
        r_dirty           <= 1'b1;
      end
      if (w_commit && r_dirty) begin
        r_active <= r_shadow;
        r_dirty  <= 1'b0;
      end
    end
  end

  assign wr_ready       = r_ready;
  assign Digitron_Out   = r_segs;
  assign DigitronCS_Out = r_cs;
  assign scan_idx       = r_idx;
  assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_digitron_scan_ctrl.sv
// Self-checking bench for digitron_scan_ctrl: frame-position model plus
// directed scenarios with literal expectations (honours LEADING_ZERO_BLANK_EN).
module tb_digitron_scan_ctrl;

  localparam int T     = 10;
  localparam int B     = 2;
  localparam int FRAME = 4 * T;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic [7:0] Digitron_Out;
  logic [3:0] DigitronCS_Out;
  logic [1:0] scan_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  digitron_scan_ctrl #(.TICK_CYCLES(T), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RSTn(RSTn), .enable(enable),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .Digitron_Out(Digitron_Out), .DigitronCS_Out(DigitronCS_Out),
    .scan_idx(scan_idx), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tbl [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                               7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

  // Model: m_p counts cycles since the current scan run started.
  logic [4:0] m_sh  [4];
  logic [4:0] m_act [4];
  bit         m_dirty  = 1'b0;
  bit         m_run    = 1'b0;
  bit         m_ready  = 1'b0;
  bit         m_fd     = 1'b0;
  bit         m_seen   = 1'b0;
  bit         m_commit = 1'b0;
  int         m_p      = 0;

  function automatic logic [7:0] enc(input logic [4:0] d);
    return {d[4], seg_tbl[d[3:0]]};
  endfunction

  function automatic logic [7:0] exp_segs(input int slot);
    bit blank;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot != 0) begin
      blank = 1'b1;
      for (int j = slot; j < 4; j++) if (m_act[j] != 5'h00) blank = 1'b0;
    end
`endif
    return blank ? 8'h00 : enc(m_act[slot]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    if (!RSTn) begin
      m_run   = 1'b1;
      m_p     = 0;
      m_dirty = 1'b0;
      m_ready = 1'b0;
      m_fd    = 1'b0;
      m_seen  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        m_sh[i]  = 5'h00;
        m_act[i] = 5'h00;
      end
    end else begin
      m_commit = m_run && (m_p % FRAME == FRAME - 1);
      m_fd     = 1'b0;
      if (wr_valid && m_ready) begin
        m_sh[wr_addr] = wr_data;
        m_dirty       = 1'b1;
      end
      if (m_commit && m_dirty) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        m_dirty = 1'b0;
        m_fd    = 1'b1;
      end
      if (!enable) begin
        m_run = 1'b0;
        m_p   = 0;
      end else if (!m_run) begin
        m_run = 1'b1;
        m_p   = 0;
      end else begin
        m_p++;
      end
      m_ready = !(m_run && (m_p % FRAME == FRAME - 1));
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    int         c_slot;
    bit         c_show;
    logic [3:0] c_cs;
    logic [7:0] c_segs;
    logic [1:0] c_idx;
    @(negedge CLK);
    if (m_seen) begin
      c_slot = (m_p / T) % 4;
      c_show = m_run && ((m_p % T) >= B);
      c_cs   = 4'hf;
      c_segs = 8'h00;
      if (c_show) begin
        c_cs   = ~(4'b0001 << c_slot);
        c_segs = exp_segs(c_slot);
      end
      c_idx = m_run ? 2'(c_slot) : 2'd0;
      chk("model_cs",    32'(DigitronCS_Out), 32'(c_cs));
      chk("model_segs",  32'(Digitron_Out),   32'(c_segs));
      chk("model_idx",   32'(scan_idx),       32'(c_idx));
      chk("model_ready", 32'(wr_ready),       32'(m_ready));
      chk("model_fd",    32'(frame_done),     32'(m_fd));
    end
  end

  task automatic wait_pos(input int tgt);
    int k;
    k = 0;
    while (!(m_run && m_p == tgt) && k < 2000) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: position %0d not reached, at %0d", tgt, m_p);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"},    32'(DigitronCS_Out), 'hf);
    chk({tag, "_segs"},  32'(Digitron_Out),   'h00);
    chk({tag, "_ready"}, 32'(wr_ready),       'h0);
    chk({tag, "_fd"},    32'(frame_done),     'h0);
    chk({tag, "_idx"},   32'(scan_idx),       'h0);
  endtask

  task automatic write1(input logic [1:0] a, input logic [4:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge CLK);
  endtask

  initial begin
    RSTn = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 5'h00;
    repeat (3) @(negedge CLK);
    chk_reset_outputs("reset");

    // Plain scan after reset: 2 dark cycles, then digit 0 shows 0.
    RSTn = 1'b1; enable = 1'b1;
    wait_pos(1);  chk("t1_blank_cs", 32'(DigitronCS_Out), 'hf);
    wait_pos(2);  chk("t1_show_cs", 32'(DigitronCS_Out), 'he);
                  chk("t1_show_segs", 32'(Digitron_Out), 'h3f);
    wait_pos(9);  chk("t1_last_show_cs", 32'(DigitronCS_Out), 'he);
    wait_pos(10); chk("t1_slot1_blank", 32'(DigitronCS_Out), 'hf);
                  chk("t1_slot1_idx", 32'(scan_idx), 'h1);
    wait_pos(32); chk("t1_slot3_cs", 32'(DigitronCS_Out), 'h7);
                  chk("t1_slot3_segs", 32'(Digitron_Out), 'h3f);

    // Burst write mid-frame: nothing visible until the commit.
    write1(2'd0, 5'h05);
    write1(2'd1, 5'h1a);
    write1(2'd2, 5'h03);
    write1(2'd3, 5'h0f);
    wr_valid = 1'b0;
    wait_pos(37); chk("t2_no_tear", 32'(Digitron_Out), 'h3f);
    wait_pos(40); chk("t2_fd_pulse", 32'(frame_done), 'h1);
    wait_pos(41); chk("t2_fd_single", 32'(frame_done), 'h0);
    wait_pos(42); chk("t2_d0", 32'(Digitron_Out), 'h6d); chk("t2_cs0", 32'(DigitronCS_Out), 'he);
    wait_pos(52); chk("t2_d1", 32'(Digitron_Out), 'hf7); chk("t2_cs1", 32'(DigitronCS_Out), 'hd);
    wait_pos(62); chk("t2_d2", 32'(Digitron_Out), 'h4f); chk("t2_cs2", 32'(DigitronCS_Out), 'hb);
    wait_pos(72); chk("t2_d3", 32'(Digitron_Out), 'h71); chk("t2_cs3", 32'(DigitronCS_Out), 'h7);

    // Write held across the commit cycle.
    wait_pos(78); chk("t3_ready_before", 32'(wr_ready), 'h1);
    wait_pos(79); chk("t3_ready_commit", 32'(wr_ready), 'h0);
    wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 5'h08;
    wait_pos(80); chk("t3_no_fd", 32'(frame_done), 'h0); chk("t3_ready_after", 32'(wr_ready), 'h1);
    wait_pos(81); wr_valid = 1'b0;
    wait_pos(82); chk("t3_old_digit", 32'(Digitron_Out), 'h6d);
    wait_pos(120); chk("t3_fd", 32'(frame_done), 'h1);
    wait_pos(122); chk("t3_new_digit", 32'(Digitron_Out), 'h7f);

    // Drop enable while digit 2 is lit; write while idle; re-enable.
    wait_pos(144); chk("t4_d2_cs", 32'(DigitronCS_Out), 'hb); chk("t4_d2_segs", 32'(Digitron_Out), 'h4f);
    enable = 1'b0;
    @(negedge CLK);
    chk("t4_idle_cs", 32'(DigitronCS_Out), 'hf);
    chk("t4_idle_segs", 32'(Digitron_Out), 'h00);
    chk("t4_idle_ready", 32'(wr_ready), 'h1);
    write1(2'd3, 5'h01);
    wr_valid = 1'b0;
    repeat (3) @(negedge CLK);
    chk("t4_still_dark", 32'(DigitronCS_Out), 'hf);
    enable = 1'b1;
    wait_pos(0);  chk("t4_restart_idx", 32'(scan_idx), 'h0); chk("t4_restart_cs", 32'(DigitronCS_Out), 'hf);
    wait_pos(2);  chk("t4_retained", 32'(Digitron_Out), 'h7f);
    wait_pos(40); chk("t4_idle_write_fd", 32'(frame_done), 'h1);
    wait_pos(72); chk("t4_idle_write_shown", 32'(Digitron_Out), 'h06);

    // Reset in the middle of a write burst.
    wait_pos(75);
    write1(2'd1, 5'h02);
    RSTn = 1'b0; wr_data = 5'h04;
    @(negedge CLK);
    chk_reset_outputs("t5_reset");
    RSTn = 1'b1; wr_valid = 1'b0;
    wait_pos(2);  chk("t5_cleared", 32'(Digitron_Out), 'h3f); chk("t5_cs", 32'(DigitronCS_Out), 'he);
    wait_pos(40); chk("t5_no_commit", 32'(frame_done), 'h0);
    wait_pos(52); chk("t5_d1_zero", 32'(Digitron_Out), 'h3f);

    // Digits {3..0} = {0,0,7,0}, then dp on digit 3.
    write1(2'd1, 5'h07);
    wr_valid = 1'b0;
    wait_pos(82);  chk("t6_d0", 32'(Digitron_Out), 'h3f);
    wait_pos(92);  chk("t6_d1", 32'(Digitron_Out), 'h07);
`ifdef LEADING_ZERO_BLANK_EN
    wait_pos(102); chk("t6_d2_lz", 32'(Digitron_Out), 'h00);
    wait_pos(112); chk("t6_d3_lz", 32'(Digitron_Out), 'h00);
                   chk("t6_d3_cs", 32'(DigitronCS_Out), 'h7);
`else
    wait_pos(102); chk("t6_d2", 32'(Digitron_Out), 'h3f);
    wait_pos(112); chk("t6_d3", 32'(Digitron_Out), 'h3f);
`endif
    write1(2'd3, 5'h10);
    wr_valid = 1'b0;
    wait_pos(142); chk("t6_dp_d2", 32'(Digitron_Out), 'h3f);
    wait_pos(152); chk("t6_dp_d3", 32'(Digitron_Out), 'hbf);

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
